// File: rtl/accumulator_4_bit_pkg.sv
// rtl/accumulator_4_bit_pkg.sv - shared state encoding and data width for the burst accumulator
package accumulator_4_bit_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_4_bit.sv
// rtl/full_adder_4_bit.sv - 4-bit ripple-carry adder built from per-bit full-adder equations
module full_adder_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic c1;
  logic c2;
  logic c3;

  // Explicit ripple chain: each stage produces its sum bit and passes its carry up.
  always_comb begin
    sum[0] = a[0] ^ b[0] ^ cin;
    c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
    sum[1] = a[1] ^ b[1] ^ c1;
    c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
    sum[2] = a[2] ^ b[2] ^ c2;
    c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
    sum[3] = a[3] ^ b[3] ^ c3;
    cout   = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));
  end

endmodule

// File: rtl/accumulator_4_bit.sv
// rtl/accumulator_4_bit.sv - counted-burst 4-bit accumulator with sticky carry flag and result handshake
module accumulator_4_bit
  import accumulator_4_bit_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] din,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] sum,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t            state;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] acc;
  logic              ovf_q;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;

  // Single adder: the accumulator is always the A operand, the incoming word the B operand.
  full_adder_4_bit u_adder (
    .a    (acc),
    .b    (din),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Handshake flags decode the registered state; in_ready is high for every ACCUM cycle.
  always_comb begin
    in_ready  = (state == S_ACCUM);
    out_valid = (state == S_DONE);
    sum       = acc;
    ovf       = ovf_q;
  end

  // Burst FSM with down-counter; acc/ovf are cleared only when a new burst starts so
  // the last result stays readable in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      acc       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= count;
            acc       <= '0;
            ovf_q     <= 1'b0;
            state     <= (count == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc       <= add_sum;
            ovf_q     <= ovf_q | add_cout;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_4_bit.sv
// tb/tb_accumulator_4_bit.sv - directed self-checking bench for the burst accumulator
module tb_accumulator_4_bit;
  import accumulator_4_bit_pkg::*;

  localparam int CNT_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] din;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] sum;
  logic              ovf;
  logic              out_valid;
  logic              out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accumulator_4_bit #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled there too.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic vld,
                            input logic [3:0] s, input logic o);
    check_eq({tag, ".in_ready"},  8'(in_ready),  8'(rdy));
    check_eq({tag, ".out_valid"}, 8'(out_valid), 8'(vld));
    check_eq({tag, ".sum"},       8'(sum),       8'(s));
    check_eq({tag, ".ovf"},       8'(ovf),       8'(o));
  endtask

  task automatic start_burst(input logic [CNT_W-1:0] n);
    start = 1'b1;
    count = n;
    cyc();
    start = 1'b0;
    check_eq("start.in_ready",  8'(in_ready),  8'(n != 0));
    check_eq("start.out_valid", 8'(out_valid), 8'(n == 0));
  endtask

  task automatic send(input logic [3:0] d, input int gaps, input logic [3:0] hold_sum);
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      din      = 4'hf;
      cyc();
      check_eq("gap.in_ready", 8'(in_ready), 8'd1);
      check_eq("gap.sum_hold", 8'(sum), 8'(hold_sum));
    end
    in_valid = 1'b1;
    din      = d;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic finish_burst(input logic [3:0] s);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check_outs("handshake", 1'b0, 1'b0, s, ovf);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; din = '0; in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    cyc();
    check_outs("reset", 1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;

    // 1 + 1
    start_burst(3'd2);
    send(4'h1, 0, 4'h0);
    check_outs("b1.mid", 1'b1, 1'b0, 4'h1, 1'b0);
    send(4'h1, 0, 4'h1);
    check_outs("b1.done", 1'b0, 1'b1, 4'h2, 1'b0);
    finish_burst(4'h2);
    check_eq("b1.idle_ovf", 8'(ovf), 8'd0);

    // 8 + 8 wraps to 0 with carry
    start_burst(3'd2);
    send(4'h8, 0, 4'h0);
    check_outs("b2.mid", 1'b1, 1'b0, 4'h8, 1'b0);
    send(4'h8, 0, 4'h8);
    check_outs("b2.done", 1'b0, 1'b1, 4'h0, 1'b1);
    finish_burst(4'h0);
    check_eq("b2.idle_ovf", 8'(ovf), 8'd1);

    // 6 + 1 + 2 with in_valid gaps
    start_burst(3'd3);
    check_eq("b3.ovf_cleared", 8'(ovf), 8'd0);
    send(4'h6, 1, 4'h0);
    send(4'h1, 2, 4'h6);
    check_outs("b3.mid", 1'b1, 1'b0, 4'h7, 1'b0);
    send(4'h2, 0, 4'h7);
    check_outs("b3.done", 1'b0, 1'b1, 4'h9, 1'b0);
    finish_burst(4'h9);

    // Zero-length burst clears the previous result
    start_burst(3'd0);
    check_outs("b4.done", 1'b0, 1'b1, 4'h0, 1'b0);
    finish_burst(4'h0);

    // Maximum burst: 7 x 3 = 21 -> 5, with carry
    start_burst(3'd7);
    for (int i = 0; i < 6; i++) send(4'h3, 0, 4'h0);
    check_outs("b5.mid", 1'b1, 1'b0, 4'h2, 1'b1);
    send(4'h3, 0, 4'h2);
    check_outs("b5.done", 1'b0, 1'b1, 4'h5, 1'b1);
    finish_burst(4'h5);

    // 9 + 9 = 2 with carry, then stall in DONE with a stray start
    start_burst(3'd2);
    send(4'h9, 0, 4'h0);
    send(4'h9, 0, 4'h9);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      count = 3'd1;
      cyc();
      check_outs("stall", 1'b0, 1'b1, 4'h2, 1'b1);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    cyc();
    start     = 1'b0;
    out_ready = 1'b0;
    check_outs("stall.release", 1'b0, 1'b0, 4'h2, 1'b1);
    cyc();
    check_outs("stall.no_queue", 1'b0, 1'b0, 4'h2, 1'b1);

    // Reset mid-burst discards partial work and the reset-cycle input
    start_burst(3'd3);
    send(4'h5, 0, 4'h0);
    rst      = 1'b1;
    in_valid = 1'b1;
    din      = 4'h3;
    cyc();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_outs("mid_reset", 1'b0, 1'b0, 4'h0, 1'b0);
    cyc();
    check_outs("mid_reset.idle", 1'b0, 1'b0, 4'h0, 1'b0);
    start_burst(3'd1);
    send(4'h7, 0, 4'h0);
    check_outs("b7.done", 1'b0, 1'b1, 4'h7, 1'b0);
    finish_burst(4'h7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
